// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Control sequencer for a tiny 4-bit-instruction CPU. Every instruction takes
// two cycles: FETCH latches the ROM word addressed by the program counter into
// an instruction register, and EXEC decodes it, drives the datapath controls
// and updates the program counter and the carry flag. A HALT instruction parks
// the sequencer until start restarts execution from address 0.
//
// Instruction word: [3:2] opcode, [1:0] argument
//   00 LOAD : register <- external data                 pc <= pc+1
//   01 ALU  : register <- ALU(arg), carry_flag <- carry pc <= pc+1
//   10 JC   : if carry_flag, pc <= {arg,0}, else         pc <= pc+1
//   11 arg=00 HALT (pc held), any other arg NOP          pc <= pc+1
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rstn       : synchronous active-low reset
//   start      : begin execution from IDLE or HALT (ignored while busy)
//   rom_data   : instruction word from a combinational ROM at rom_addr
//   carry_in   : ALU carry-out for the current operands
//   rom_addr   : ROM address, always equal to pc_out
//   pc_out     : current program counter
//   mux_sel    : register input select, 0 = external data, 1 = ALU result
//   reg_load   : register load enable, one-cycle pulse in EXEC
//   alu_op     : ALU operation code
//   carry_flag : latched carry
//   busy       : high in FETCH and EXEC
//   halted     : high only in HALT
//   instr_done : one-cycle pulse in the EXEC cycle of every instruction
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int PC_W = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [3:0]      rom_data,
    input  logic            carry_in,
    output logic [PC_W-1:0] rom_addr,
    output logic [PC_W-1:0] pc_out,
    output logic            mux_sel,
    output logic            reg_load,
    output logic [1:0]      alu_op,
    output logic            carry_flag,
    output logic            busy,
    output logic            halted,
    output logic            instr_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ALU  = 2'b01;
    localparam logic [1:0] OP_JC   = 2'b10;
    localparam logic [1:0] OP_MISC = 2'b11;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [3:0]      ir_reg, ir_next;
    logic            carry_reg, carry_next;

    logic [1:0]      opcode;
    logic [1:0]      arg;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jc_target;

    assign opcode = ir_reg[3:2];
    assign arg    = ir_reg[1:0];

    // Both the increment and the jump target live in PC_W bits, so they wrap
    // modulo 2^PC_W without any extra logic.
    assign pc_inc    = pc_reg + PC_W'(1);
    assign jc_target = PC_W'({arg, 1'b0});

    assign pc_out     = pc_reg;
    assign rom_addr   = pc_reg;
    assign carry_flag = carry_reg;

    // Reset wins over everything, including an EXEC update in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            ir_reg    <= '0;
            carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            carry_reg <= carry_next;
        end
    end

    // Next-state logic and datapath controls. The controls depend only on the
    // current state and ir, so the reg_load of an EXEC cycle stays visible
    // even if reset is asserted in that same cycle.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        carry_next = carry_reg;
        mux_sel    = 1'b0;
        reg_load   = 1'b0;
        alu_op     = 2'b00;
        busy       = 1'b0;
        halted     = 1'b0;
        instr_done = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Leaving IDLE keeps whatever pc holds.
                if (start) begin
                    state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                busy       = 1'b1;
                ir_next    = rom_data;
                state_next = ST_EXEC;
            end

            ST_EXEC: begin
                busy       = 1'b1;
                instr_done = 1'b1;
                state_next = ST_FETCH;
                case (opcode)
                    OP_LOAD: begin
                        reg_load = 1'b1;
                        pc_next  = pc_inc;
                    end
                    OP_ALU: begin
                        mux_sel    = 1'b1;
                        alu_op     = arg;
                        reg_load   = 1'b1;
                        carry_next = carry_in;
                        pc_next    = pc_inc;
                    end
                    OP_JC: begin
                        pc_next = carry_reg ? jc_target : pc_inc;
                    end
                    OP_MISC: begin
                        if (arg == 2'b00) begin
                            state_next = ST_HALT;
                        end else begin
                            pc_next = pc_inc;
                        end
                    end
                    default: begin
                        pc_next = pc_inc;
                    end
                endcase
            end

            ST_HALT: begin
                halted = 1'b1;
                // Restart always begins a fresh program from address 0.
                if (start) begin
                    state_next = ST_FETCH;
                    pc_next    = '0;
                    carry_next = 1'b0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Self-checking bench for cpu_sequencer. A combinational ROM array feeds the
// DUT; an instruction-level reference model (program counter, carry and a
// halted flag, stepped once per instruction) provides expected values for
// every FETCH/EXEC cycle. Directed scenarios cover the programs called out
// for this block; a randomized run exercises arbitrary ROM contents and
// carry inputs.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

    localparam int PC_W = 3;

    localparam logic [3:0] I_LOAD = 4'b0000;
    localparam logic [3:0] I_HALT = 4'b1100;
    localparam logic [3:0] I_NOP  = 4'b1101;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic [3:0]      rom_data;
    logic            carry_in;
    logic [PC_W-1:0] rom_addr;
    logic [PC_W-1:0] pc_out;
    logic            mux_sel;
    logic            reg_load;
    logic [1:0]      alu_op;
    logic            carry_flag;
    logic            busy;
    logic            halted;
    logic            instr_done;

    logic [3:0] rom [8];

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state only.
    logic [PC_W-1:0] m_pc;
    logic            m_carry;
    logic            m_halted;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    cpu_sequencer #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .rom_data   (rom_data),
        .carry_in   (carry_in),
        .rom_addr   (rom_addr),
        .pc_out     (pc_out),
        .mux_sel    (mux_sel),
        .reg_load   (reg_load),
        .alu_op     (alu_op),
        .carry_flag (carry_flag),
        .busy       (busy),
        .halted     (halted),
        .instr_done (instr_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom(input logic [3:0] word);
        for (int i = 0; i < 8; i++) rom[i] = word;
    endtask

    // Apply reset for one edge, then release it for one idle edge.
    task automatic do_reset(input string tag);
        rstn  = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || reg_load !== 1'b0 || mux_sel !== 1'b0 ||
            alu_op !== 2'b00 || instr_done !== 1'b0 || pc_out !== 3'd0 || carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL %s in_reset: busy=%b halted=%b load=%b mux=%b alu=%b done=%b pc=%0d carry=%b, exp all 0",
                     tag, busy, halted, reg_load, mux_sel, alu_op, instr_done, pc_out, carry_flag);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || reg_load !== 1'b0 || mux_sel !== 1'b0 ||
            alu_op !== 2'b00 || instr_done !== 1'b0 || pc_out !== 3'd0 || carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL %s after_reset: busy=%b halted=%b load=%b mux=%b alu=%b done=%b pc=%0d carry=%b, exp all 0",
                     tag, busy, halted, reg_load, mux_sel, alu_op, instr_done, pc_out, carry_flag);
        end
        m_pc     = '0;
        m_carry  = 1'b0;
        m_halted = 1'b0;
        $display("%s: reset applied", tag);
    endtask

    // Pulse start from IDLE or HALT; leaves the bench in the first FETCH cycle.
    task automatic launch(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_halted) begin
            m_pc     = '0;
            m_carry  = 1'b0;
            m_halted = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || halted !== 1'b0 || pc_out !== m_pc || carry_flag !== m_carry) begin
            errors++;
            $display("FAIL %s launch: busy=%b halted=%b pc=%0d carry=%b, exp busy=1 halted=0 pc=%0d carry=%b",
                     tag, busy, halted, pc_out, carry_flag, m_pc, m_carry);
        end
        $display("%s: start -> pc=%0d", tag, m_pc);
    endtask

    // Run one instruction starting in its FETCH cycle and check every cycle.
    task automatic exec_instr(input string tag, input logic cin);
        logic [3:0] word;
        logic [1:0] op;
        logic [1:0] arg;
        logic       exp_load;
        logic       exp_mux;
        logic [1:0] exp_alu;
        word = rom[m_pc];
        op   = word[3:2];
        arg  = word[1:0];

        checks++;
        if (busy !== 1'b1 || instr_done !== 1'b0 || reg_load !== 1'b0 || mux_sel !== 1'b0 ||
            alu_op !== 2'b00 || halted !== 1'b0 || pc_out !== m_pc || rom_addr !== m_pc) begin
            errors++;
            $display("FAIL %s fetch: busy=%b done=%b load=%b mux=%b alu=%b halted=%b pc=%0d addr=%0d, exp 1 0 0 0 00 0 pc=%0d",
                     tag, busy, instr_done, reg_load, mux_sel, alu_op, halted, pc_out, rom_addr, m_pc);
        end

        carry_in = cin;
        tick();
        exp_load = (op == 2'b00) || (op == 2'b01);
        exp_mux  = (op == 2'b01);
        exp_alu  = (op == 2'b01) ? arg : 2'b00;
        checks++;
        if (reg_load !== exp_load || mux_sel !== exp_mux || alu_op !== exp_alu || instr_done !== 1'b1 ||
            busy !== 1'b1 || halted !== 1'b0 || pc_out !== m_pc || carry_flag !== m_carry) begin
            errors++;
            $display("FAIL %s exec word=%h: load=%b mux=%b alu=%b done=%b busy=%b halted=%b pc=%0d carry=%b, exp load=%b mux=%b alu=%b done=1 busy=1 halted=0 pc=%0d carry=%b",
                     tag, word, reg_load, mux_sel, alu_op, instr_done, busy, halted, pc_out, carry_flag,
                     exp_load, exp_mux, exp_alu, m_pc, m_carry);
        end

        case (op)
            2'b00: m_pc = m_pc + 1'b1;
            2'b01: begin
                m_carry = cin;
                m_pc    = m_pc + 1'b1;
            end
            2'b10: m_pc = m_carry ? {arg, 1'b0} : m_pc + 1'b1;
            default: begin
                if (arg == 2'b00) m_halted = 1'b1;
                else              m_pc = m_pc + 1'b1;
            end
        endcase

        tick();
        checks++;
        if (halted !== m_halted || busy !== !m_halted || instr_done !== 1'b0 ||
            pc_out !== m_pc || carry_flag !== m_carry) begin
            errors++;
            $display("FAIL %s after word=%h: halted=%b busy=%b done=%b pc=%0d carry=%b, exp halted=%b busy=%b done=0 pc=%0d carry=%b",
                     tag, word, halted, busy, instr_done, pc_out, carry_flag, m_halted, !m_halted, m_pc, m_carry);
        end
        $display("%s: word=%h cin=%b -> pc=%0d carry=%b halted=%b", tag, word, cin, m_pc, m_carry, m_halted);
    endtask

    task automatic test_reset();
        fill_rom(I_NOP);
        carry_in = 1'b0;
        do_reset("reset");
    endtask

    // LOAD, ALU op01, NOP, HALT: cycle-exact control pattern.
    task automatic test_program();
        logic [7:0] load_v;
        logic [7:0] mux_v;
        logic [7:0] halt_v;
        logic [1:0] alu_c2;
        logic [1:0] alu_c4;
        fill_rom(I_NOP);
        rom[0] = I_LOAD;
        rom[1] = 4'b0101;
        rom[2] = I_NOP;
        rom[3] = I_HALT;
        do_reset("program");
        carry_in = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        alu_c2 = 2'b11;
        alu_c4 = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            load_v[c-1] = reg_load;
            mux_v[c-1]  = mux_sel;
            halt_v[c-1] = halted;
            if (c == 2) alu_c2 = alu_op;
            if (c == 4) alu_c4 = alu_op;
            tick();
        end
        checks++;
        if (load_v !== 8'b0000_1010) begin
            errors++;
            $display("FAIL program reg_load cycles: got %b exp %b", load_v, 8'b0000_1010);
        end
        checks++;
        if (mux_v !== 8'b0000_1000) begin
            errors++;
            $display("FAIL program mux_sel cycles: got %b exp %b", mux_v, 8'b0000_1000);
        end
        checks++;
        if (alu_c2 !== 2'b00 || alu_c4 !== 2'b01) begin
            errors++;
            $display("FAIL program alu_op: cycle2=%b cycle4=%b exp 00 01", alu_c2, alu_c4);
        end
        checks++;
        if (halt_v !== 8'b0 || halted !== 1'b1 || pc_out !== 3'd3) begin
            errors++;
            $display("FAIL program halt: during=%b halted=%b pc=%0d exp during=0 halted=1 pc=3", halt_v, halted, pc_out);
        end
        $display("program: halted=%b pc=%0d", halted, pc_out);
    endtask

    // ALU at pc0 then JC arg=10 at pc1, with carry set and then clear.
    task automatic test_jc();
        fill_rom(I_HALT);
        rom[0] = 4'b0110;
        rom[1] = 4'b1010;
        do_reset("jc");
        launch("jc");
        exec_instr("jc_taken", 1'b1);
        exec_instr("jc_taken", 1'b0);
        checks++;
        if (pc_out !== 3'd4) begin
            errors++;
            $display("FAIL jc_taken target: pc=%0d exp 4", pc_out);
        end
        exec_instr("jc_taken", 1'b0);
        launch("jc");
        exec_instr("jc_not", 1'b0);
        exec_instr("jc_not", 1'b1);
        checks++;
        if (pc_out !== 3'd2) begin
            errors++;
            $display("FAIL jc_not fallthrough: pc=%0d exp 2", pc_out);
        end
    endtask

    // Eight NOPs walk pc 0..7 and wrap to 0.
    task automatic test_nop_wrap();
        fill_rom(I_NOP);
        do_reset("wrap");
        launch("wrap");
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pc_out !== 3'(i)) begin
                errors++;
                $display("FAIL wrap pc: got %0d exp %0d", pc_out, i);
            end
            exec_instr("wrap", 1'($urandom_range(0, 1)));
        end
        checks++;
        if (pc_out !== 3'd0) begin
            errors++;
            $display("FAIL wrap final pc: got %0d exp 0", pc_out);
        end
    endtask

    // start held high while running, then restart out of HALT.
    task automatic test_start_held();
        fill_rom(I_NOP);
        rom[0] = 4'b0111;
        rom[3] = I_HALT;
        do_reset("held");
        start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) exec_instr("held", (i == 0) ? 1'b1 : 1'b0);
        tick();
        m_pc     = '0;
        m_carry  = 1'b0;
        m_halted = 1'b0;
        checks++;
        if (busy !== 1'b1 || halted !== 1'b0 || pc_out !== 3'd0 || carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL held restart: busy=%b halted=%b pc=%0d carry=%b exp busy=1 halted=0 pc=0 carry=0",
                     busy, halted, pc_out, carry_flag);
        end
        start = 1'b0;
        $display("held: restart from halt -> pc=%0d", pc_out);
    endtask

    // Reset during the EXEC cycle of an ALU op with carry_in=1.
    task automatic test_reset_exec();
        fill_rom(I_NOP);
        rom[1] = 4'b0111;
        do_reset("rst_exec");
        launch("rst_exec");
        exec_instr("rst_exec", 1'b0);
        carry_in = 1'b1;
        tick();
        rstn = 1'b0;
        #1;
        checks++;
        if (reg_load !== 1'b1 || mux_sel !== 1'b1 || alu_op !== 2'b11) begin
            errors++;
            $display("FAIL rst_exec controls: load=%b mux=%b alu=%b exp 1 1 11", reg_load, mux_sel, alu_op);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || pc_out !== 3'd0 || carry_flag !== 1'b0 || reg_load !== 1'b0) begin
            errors++;
            $display("FAIL rst_exec after: busy=%b halted=%b pc=%0d carry=%b load=%b exp 0 0 0 0 0",
                     busy, halted, pc_out, carry_flag, reg_load);
        end
        rstn = 1'b1;
        carry_in = 1'b0;
        m_pc = '0;
        m_carry = 1'b0;
        m_halted = 1'b0;
        $display("rst_exec: reset mid-ALU -> pc=%0d carry=%b", pc_out, carry_flag);
    endtask

    // Random ROM contents and carries against the reference model.
    task automatic test_random();
        for (int i = 0; i < 8; i++) rom[i] = 4'($urandom_range(0, 15));
        do_reset("rand");
        launch("rand");
        for (int n = 0; n < 80; n++) begin
            if (m_halted) begin
                for (int i = 0; i < 8; i++) rom[i] = 4'($urandom_range(0, 15));
                launch("rand");
            end else begin
                exec_instr("rand", 1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        rstn     = 1'b0;
        start    = 1'b0;
        carry_in = 1'b0;
        m_pc     = '0;
        m_carry  = 1'b0;
        m_halted = 1'b0;
        fill_rom(I_NOP);
        test_reset();
        test_program();
        test_jc();
        test_nop_wrap();
        test_start_held();
        test_reset_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
